// File: rtl/rv_iopmp_pkg.sv
// Shared definitions for the IOPMP blocks.
//   RESP_*          : AXI response codes.
//   err_wr_state_e  : write-side states of the error responder.
//   err_rd_state_e  : read-side states of the error responder.
package rv_iopmp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DRAIN = 2'd1,
    W_RESP  = 2'd2
  } err_wr_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } err_rd_state_e;

endpackage

// File: rtl/rv_iopmp_err_rd_burst.sv
// Read half of the IOPMP error responder: accepts one denied AR at a time
// and plays back a full R burst of len+1 zero-data beats carrying RESP_CODE.
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    : denied AR handshake
//   req_id_i, req_len_i        : AR id and len (beats-1) of the denied read
//   r_valid_o/r_ready_i        : R channel handshake
//   r_id_o, r_data_o, r_resp_o : R payload (data always zero)
//   r_last_o                   : final beat marker
//   busy_o                     : burst in progress
module rv_iopmp_err_rd_burst
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [1:0]  RESP_CODE  = RESP_SLVERR
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  input  logic [7:0]            req_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  busy_o
);

  err_rd_state_e         state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  // Holds the request port closed while reset is active and for the first
  // edge after release, so every handshake output reads 0 during reset
  // while still being decoded purely from flops.
  logic                  armed_q;

  assign req_ready_o = armed_q && (state_q == R_IDLE);
  assign r_valid_o   = (state_q == R_BURST);
  assign r_id_o      = id_q;
  assign r_data_o    = '0;
  assign r_resp_o    = RESP_CODE;
  // Equality compare ends the burst at beat len, so len=255 finishes on the
  // 256th beat before the 8-bit counter could wrap.
  assign r_last_o    = (state_q == R_BURST) && (cnt_q == len_q);
  assign busy_o      = (state_q != R_IDLE);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      R_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          id_d    = req_id_i;
          len_d   = req_len_i;
          cnt_d   = 8'd0;
          state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (r_ready_i) begin
          if (cnt_q == len_q) begin
            state_d = R_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= R_IDLE;
      id_q    <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/rv_iopmp_err_responder.sv
// Terminal AXI responder for IOPMP-denied transactions. Denied writes have
// their W beats drained and get a single error B response; denied reads get
// a full error R burst, so the upstream master always sees completion.
// Ports:
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   wr_req_valid_i/ready_o, wr_req_id_i : denied AW handshake and id
//   w_valid_i/w_ready_o, w_last_i       : W beats to discard
//   b_valid_o/b_ready_i, b_id_o, b_resp_o : error B response
//   rd_req_valid_i/ready_o, rd_req_id_i, rd_req_len_i : denied AR
//   r_valid_o/r_ready_i, r_id_o, r_data_o, r_resp_o, r_last_o : error R burst
//   busy_o                              : either direction not idle
module rv_iopmp_err_responder
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [1:0]  RESP_CODE  = RESP_SLVERR
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_req_valid_i,
  output logic                  wr_req_ready_o,
  input  logic [ID_WIDTH-1:0]   wr_req_id_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  rd_req_valid_i,
  output logic                  rd_req_ready_o,
  input  logic [ID_WIDTH-1:0]   rd_req_id_i,
  input  logic [7:0]            rd_req_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  busy_o
);

  err_wr_state_e       wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0] wr_id_q, wr_id_d;
  // Keeps wr_req_ready_o low during reset and the first edge after release.
  logic                wr_armed_q;
  logic                rd_busy;

  // Ready/valid are decoded from flops only: no path from any valid input.
  assign wr_req_ready_o = wr_armed_q && (wr_state_q == W_IDLE);
  assign w_ready_o      = (wr_state_q == W_DRAIN);
  assign b_valid_o      = (wr_state_q == W_RESP);
  assign b_id_o         = wr_id_q;
  assign b_resp_o       = RESP_CODE;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req_valid_i && wr_req_ready_o) begin
          wr_id_d    = wr_req_id_i;
          wr_state_d = W_DRAIN;
        end
      end
      W_DRAIN: begin
        // W data is simply dropped; only the last marker matters.
        if (w_valid_i && w_last_i) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_armed_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_armed_q <= 1'b1;
    end
  end

  rv_iopmp_err_rd_burst #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESP_CODE  (RESP_CODE)
  ) u_rd_burst (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (rd_req_valid_i),
    .req_ready_o (rd_req_ready_o),
    .req_id_i    (rd_req_id_i),
    .req_len_i   (rd_req_len_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_id_o      (r_id_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .busy_o      (rd_busy)
  );

  assign busy_o = (wr_state_q != W_IDLE) || rd_busy;

endmodule

// File: tb/tb_rv_iopmp_err_responder.sv
module tb_rv_iopmp_err_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (SLVERR)
  logic        wr_req_valid = 1'b0, wr_req_ready;
  logic [7:0]  wr_req_id = 8'd0;
  logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
  logic        b_valid, b_ready = 1'b1;
  logic [7:0]  b_id;
  logic [1:0]  b_resp;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [7:0]  rd_req_id = 8'd0, rd_req_len = 8'd0;
  logic        r_valid, r_ready = 1'b1, r_last, busy;
  logic [7:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  // DECERR instance
  logic        d_wr_req_valid = 1'b0, d_wr_req_ready;
  logic        d_w_valid = 1'b0, d_w_ready;
  logic        d_b_valid;
  logic [7:0]  d_b_id;
  logic [1:0]  d_b_resp;
  logic        d_rd_req_valid = 1'b0, d_rd_req_ready;
  logic        d_r_valid, d_r_last, d_busy;
  logic [7:0]  d_r_id;
  logic [63:0] d_r_data;
  logic [1:0]  d_r_resp;

  rv_iopmp_err_responder #(.ID_WIDTH(8), .DATA_WIDTH(64), .RESP_CODE(2'b10)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_req_valid_i(wr_req_valid), .wr_req_ready_o(wr_req_ready), .wr_req_id_i(wr_req_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready), .rd_req_id_i(rd_req_id),
    .rd_req_len_i(rd_req_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last), .busy_o(busy)
  );

  rv_iopmp_err_responder #(.ID_WIDTH(8), .DATA_WIDTH(64), .RESP_CODE(2'b11)) u_dec (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_req_valid_i(d_wr_req_valid), .wr_req_ready_o(d_wr_req_ready), .wr_req_id_i(8'h01),
    .w_valid_i(d_w_valid), .w_ready_o(d_w_ready), .w_last_i(1'b1),
    .b_valid_o(d_b_valid), .b_ready_i(1'b1), .b_id_o(d_b_id), .b_resp_o(d_b_resp),
    .rd_req_valid_i(d_rd_req_valid), .rd_req_ready_o(d_rd_req_ready), .rd_req_id_i(8'h02),
    .rd_req_len_i(8'd0),
    .r_valid_o(d_r_valid), .r_ready_i(1'b1), .r_id_o(d_r_id), .r_data_o(d_r_data),
    .r_resp_o(d_r_resp), .r_last_o(d_r_last), .busy_o(d_busy)
  );

  typedef struct packed {
    logic [7:0] id;
    logic       last;
  } rexp_t;

  rexp_t      r_q[$];
  logic [7:0] b_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: inputs change at posedge+1, so a handshake seen at
  // the falling edge is the one that completes on the next rising edge.
  logic       r_stall = 1'b0, b_stall = 1'b0;
  logic [7:0] r_id_prev, b_id_prev;
  logic       r_last_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (r_stall) begin
        check("r_hold_valid", {63'd0, r_valid}, 64'd1);
        check("r_hold_id", {56'd0, r_id}, {56'd0, r_id_prev});
        check("r_hold_last", {63'd0, r_last}, {63'd0, r_last_prev});
      end
      if (b_stall) begin
        check("b_hold_valid", {63'd0, b_valid}, 64'd1);
        check("b_hold_id", {56'd0, b_id}, {56'd0, b_id_prev});
      end
      if (r_valid && r_ready) begin
        if (r_q.size() == 0) begin
          check("r_unexpected_beat", 64'd1, 64'd0);
        end else begin
          rexp_t e;
          e = r_q.pop_front();
          $display("[TB] R beat id=0x%0h last=%0b resp=%0b data=0x%0h", r_id, r_last, r_resp, r_data);
          check("r_id", {56'd0, r_id}, {56'd0, e.id});
          check("r_last", {63'd0, r_last}, {63'd0, e.last});
          check("r_data", r_data, 64'd0);
          check("r_resp", {62'd0, r_resp}, 64'd2);
        end
      end
      if (b_valid && b_ready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected", 64'd1, 64'd0);
        end else begin
          logic [7:0] eb;
          eb = b_q.pop_front();
          $display("[TB] B resp id=0x%0h resp=%0b", b_id, b_resp);
          check("b_id", {56'd0, b_id}, {56'd0, eb});
          check("b_resp", {62'd0, b_resp}, 64'd2);
        end
      end
      r_stall = r_valid && !r_ready;
      r_id_prev = r_id;
      r_last_prev = r_last;
      b_stall = b_valid && !b_ready;
      b_id_prev = b_id;
    end
  end

  task automatic push_rd(input logic [7:0] id, input int len);
    for (int i = 0; i <= len; i++) begin
      rexp_t e;
      e.id = id;
      e.last = (i == len);
      r_q.push_back(e);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, 64'(r_q.size() + b_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state ----
    #3;
    check("rst_wr_req_ready", {63'd0, wr_req_ready}, 64'd0);
    check("rst_rd_req_ready", {63'd0, rd_req_ready}, 64'd0);
    check("rst_w_ready", {63'd0, w_ready}, 64'd0);
    check("rst_b_valid", {63'd0, b_valid}, 64'd0);
    check("rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("rst_b_id", {56'd0, b_id}, 64'd0);
    check("rst_r_id", {56'd0, r_id}, 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_r_last", {63'd0, r_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_b_resp", {62'd0, b_resp}, 64'd2);
    check("rst_r_resp", {62'd0, r_resp}, 64'd2);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_wr_req_ready", {63'd0, wr_req_ready}, 64'd1);
    check("idle_rd_req_ready", {63'd0, rd_req_ready}, 64'd1);

    // ---- write id=0x2A, 4 beats ----
    wr_req_valid = 1'b1;
    wr_req_id = 8'h2A;
    b_q.push_back(8'h2A);
    tick();
    wr_req_valid = 1'b0;
    check("wr_w_ready_after_accept", {63'd0, w_ready}, 64'd1);
    check("wr_req_ready_in_drain", {63'd0, wr_req_ready}, 64'd0);
    check("wr_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_last = (i == 3);
      check("wr_w_ready_beat", {63'd0, w_ready}, 64'd1);
      check("wr_no_early_b", {63'd0, b_valid}, 64'd0);
      tick();
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    check("wr_b_valid_latency", {63'd0, b_valid}, 64'd1);
    check("wr_b_id", {56'd0, b_id}, 64'h2A);
    check("wr_w_ready_in_resp", {63'd0, w_ready}, 64'd0);
    tick();
    check("wr_b_valid_dropped", {63'd0, b_valid}, 64'd0);
    check("wr_turnaround_ready", {63'd0, wr_req_ready}, 64'd1);
    check_drained("wr_scoreboard_empty");

    // ---- read id=0x11, len=3 ----
    rd_req_valid = 1'b1;
    rd_req_id = 8'h11;
    rd_req_len = 8'd3;
    push_rd(8'h11, 3);
    tick();
    rd_req_valid = 1'b0;
    check("rd_ready_in_burst", {63'd0, rd_req_ready}, 64'd0);
    repeat (4) tick();
    check("rd_len3_done", {63'd0, r_valid}, 64'd0);
    check("rd_len3_ready_back", {63'd0, rd_req_ready}, 64'd1);
    check_drained("rd_len3_scoreboard_empty");

    // ---- read len=0, r_ready 0,0,1 ----
    r_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_id = 8'h44;
    rd_req_len = 8'd0;
    push_rd(8'h44, 0);
    tick();
    rd_req_valid = 1'b0;
    check("rd_len0_valid", {63'd0, r_valid}, 64'd1);
    check("rd_len0_last", {63'd0, r_last}, 64'd1);
    tick();
    tick();
    r_ready = 1'b1;
    check("rd_len0_still_valid", {63'd0, r_valid}, 64'd1);
    tick();
    check("rd_len0_done", {63'd0, r_valid}, 64'd0);
    check("rd_len0_idle", {63'd0, busy}, 64'd0);
    check_drained("rd_len0_scoreboard_empty");

    // ---- read len=255 ----
    rd_req_valid = 1'b1;
    rd_req_id = 8'hC3;
    rd_req_len = 8'd255;
    push_rd(8'hC3, 255);
    tick();
    rd_req_valid = 1'b0;
    repeat (255) tick();
    check("rd_len255_last_beat_valid", {63'd0, r_valid}, 64'd1);
    check("rd_len255_last_flag", {63'd0, r_last}, 64'd1);
    tick();
    check("rd_len255_done", {63'd0, r_valid}, 64'd0);
    check_drained("rd_len255_scoreboard_empty");

    // ---- concurrent write id=5 (2 beats) and read id=7 len=1 ----
    b_ready = 1'b0;
    wr_req_valid = 1'b1;
    wr_req_id = 8'h05;
    rd_req_valid = 1'b1;
    rd_req_id = 8'h07;
    rd_req_len = 8'd1;
    b_q.push_back(8'h05);
    push_rd(8'h07, 1);
    tick();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    check("cc_w_ready", {63'd0, w_ready}, 64'd1);
    check("cc_r_valid", {63'd0, r_valid}, 64'd1);
    w_valid = 1'b1;
    w_last = 1'b0;
    tick();
    w_last = 1'b1;
    tick();
    w_valid = 1'b0;
    w_last = 1'b0;
    check("cc_read_done", {63'd0, r_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("cc_b_valid_held", {63'd0, b_valid}, 64'd1);
      check("cc_b_id_held", {56'd0, b_id}, 64'h05);
      tick();
    end
    b_ready = 1'b1;
    check("cc_busy_while_b", {63'd0, busy}, 64'd1);
    tick();
    check("cc_b_done", {63'd0, b_valid}, 64'd0);
    check("cc_idle", {63'd0, busy}, 64'd0);
    check_drained("cc_scoreboard_empty");

    // ---- reset mid read burst ----
    rd_req_valid = 1'b1;
    rd_req_id = 8'h09;
    rd_req_len = 8'd7;
    r_q.push_back('{id: 8'h09, last: 1'b0});
    r_q.push_back('{id: 8'h09, last: 1'b0});
    tick();
    rd_req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_rd_ready", {63'd0, rd_req_ready}, 64'd0);
    check("mid_rst_r_id", {56'd0, r_id}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_req_valid = 1'b1;
    rd_req_id = 8'h03;
    rd_req_len = 8'd0;
    push_rd(8'h03, 0);
    tick();
    rd_req_valid = 1'b0;
    check("post_rst_r_id", {56'd0, r_id}, 64'h03);
    tick();
    check("post_rst_done", {63'd0, r_valid}, 64'd0);
    check_drained("post_rst_scoreboard_empty");

    // ---- DECERR instance ----
    d_wr_req_valid = 1'b1;
    tick();
    d_wr_req_valid = 1'b0;
    d_w_valid = 1'b1;
    tick();
    d_w_valid = 1'b0;
    check("dec_b_valid", {63'd0, d_b_valid}, 64'd1);
    check("dec_b_resp", {62'd0, d_b_resp}, 64'd3);
    $display("[TB] DECERR B resp=%0b", d_b_resp);
    tick();
    d_rd_req_valid = 1'b1;
    tick();
    d_rd_req_valid = 1'b0;
    check("dec_r_valid", {63'd0, d_r_valid}, 64'd1);
    check("dec_r_resp", {62'd0, d_r_resp}, 64'd3);
    check("dec_r_last", {63'd0, d_r_last}, 64'd1);
    $display("[TB] DECERR R resp=%0b", d_r_resp);
    tick();
    check("dec_r_done", {63'd0, d_r_valid}, 64'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
